// File: rtl/soml_uart_pkg.sv
// Shared constants, intake action type and byte-packing helpers for the
// UART-to-decoder word path.
package soml_uart_pkg;

    localparam int unsigned WORDS_PER_FRAME     = 48;     // 32 H words + 16 Y words
    localparam int unsigned BYTES_PER_WORD      = 4;
    localparam int unsigned UART_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
    localparam int unsigned WORD_INDEX_W        = 6;

    // What the packer does with the current cycle's inputs, in priority order.
    typedef enum logic [2:0] {
        ActNone,
        ActFlush,
        ActDrop,
        ActAppend,
        ActComplete,
        ActTimeout
    } intake_act_e;

    // Push one byte into the 3-byte partial word. MSB-first shifts left so the
    // oldest byte ends in the top lane; LSB-first shifts right so it ends in [7:0].
    function automatic logic [23:0] shift_in(input logic [23:0] partial,
                                             input logic [7:0]  b,
                                             input bit          msb_first);
        return msb_first ? {partial[15:0], b} : {b, partial[23:8]};
    endfunction

    // Combine the three held bytes with the 4th (newest) byte.
    function automatic logic [31:0] pack_word(input logic [23:0] partial,
                                              input logic [7:0]  b,
                                              input bit          msb_first);
        return msb_first ? {partial, b} : {b, partial};
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer. Counts cycles since the last load; holds at zero
// while cleared and saturates with expire high once LIMIT-1 is reached.
module uart_idle_timer
    import soml_uart_pkg::*;
#(
    parameter int unsigned LIMIT = UART_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,    // byte arrived: restart from zero
    input  logic clear,   // nothing pending: hold at zero
    output logic expire
);

    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LastCount = CW'(LIMIT - 1);
    localparam logic [CW-1:0] One       = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == LastCount);

    // Next count: restart on load/clear, otherwise advance until expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (load || clear) begin
            cnt_d = '0;
        end else if (!expire) begin
            cnt_d = cnt_q + One;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART RX bytes into 32-bit words for the SOML decoder loader and
// tracks the word position inside a frame. Partial words are discarded on
// framing errors and flushes; define UART_WORD_TIMEOUT_EN to also discard
// them after an inter-byte idle timeout.
module uart_word_packer
    import soml_uart_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = soml_uart_pkg::WORDS_PER_FRAME,
    parameter bit          MSB_FIRST       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES  = UART_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_byte_valid,
    input  logic                    rx_frame_err,
    input  logic                    flush,
    output logic [31:0]             o_data_32bit,
    output logic                    o_valid,
    output logic [WORD_INDEX_W-1:0] word_index,
    output logic                    frame_done,
    output logic [1:0]              byte_cnt,
    output logic                    resync
);

    localparam logic [WORD_INDEX_W-1:0] LastWord = WORD_INDEX_W'(WORDS_PER_FRAME - 1);
    localparam logic [WORD_INDEX_W-1:0] WcOne    = WORD_INDEX_W'(1);

    logic [1:0]              bc_q, bc_d;
    logic [23:0]             shreg_q, shreg_d;
    logic [WORD_INDEX_W-1:0] wc_q, wc_d;
    logic [31:0]             data_q, data_d;
    logic                    valid_q, valid_d;
    logic [WORD_INDEX_W-1:0] idx_q, idx_d;
    logic                    fd_q, fd_d;
    logic                    resync_q, resync_d;
    logic                    timer_expire;
    intake_act_e             act;

`ifdef UART_WORD_TIMEOUT_EN
    // Any strobe, good or bad, counts as activity; no partial word means no timing.
    uart_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (rx_byte_valid),
        .clear  (flush || (bc_q == 2'd0)),
        .expire (timer_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timer_expire       = 1'b0;
`endif

    // Decide this cycle's action: flush beats any strobe, a strobe beats the timeout.
    always_comb begin
        act = ActNone;
        if (flush) begin
            act = ActFlush;
        end else if (rx_byte_valid && rx_frame_err) begin
            act = ActDrop;
        end else if (rx_byte_valid) begin
            act = (bc_q == 2'd3) ? ActComplete : ActAppend;
        end else if (timer_expire && (bc_q != 2'd0)) begin
            act = ActTimeout;
        end
    end

    // Next-state for counters, partial word and the registered outputs.
    always_comb begin
        bc_d     = bc_q;
        shreg_d  = shreg_q;
        wc_d     = wc_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        fd_d     = 1'b0;
        resync_d = 1'b0;
        unique case (act)
            ActNone: ;
            ActFlush: begin
                bc_d     = 2'd0;
                wc_d     = '0;
                resync_d = (bc_q != 2'd0);
            end
            ActDrop: begin
                bc_d     = 2'd0;
                resync_d = (bc_q != 2'd0);
            end
            ActAppend: begin
                shreg_d = shift_in(shreg_q, rx_byte, MSB_FIRST);
                bc_d    = bc_q + 2'd1;
            end
            ActComplete: begin
                data_d  = pack_word(shreg_q, rx_byte, MSB_FIRST);
                bc_d    = 2'd0;
                valid_d = 1'b1;
                idx_d   = wc_q;
                if (wc_q == LastWord) begin
                    fd_d = 1'b1;
                    wc_d = '0;
                end else begin
                    wc_d = wc_q + WcOne;
                end
            end
            ActTimeout: begin
                bc_d     = 2'd0;
                resync_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset drops any partial word silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q     <= 2'd0;
            shreg_q  <= '0;
            wc_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            fd_q     <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            bc_q     <= bc_d;
            shreg_q  <= shreg_d;
            wc_q     <= wc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            fd_q     <= fd_d;
            resync_q <= resync_d;
        end
    end

    assign o_data_32bit = data_q;
    assign o_valid      = valid_q;
    assign word_index   = idx_q;
    assign frame_done   = fd_q;
    assign byte_cnt     = bc_q;
    assign resync       = resync_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Self-checking bench for uart_word_packer: an MSB-first and an LSB-first
// instance share one input stream; expected words are queued when their 4th
// byte is driven and compared when the DUT reports them.
module tb_uart_word_packer;

    localparam int unsigned TO  = 100;
    localparam int unsigned WPF = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        rx_frame_err;
    logic        flush;

    logic [31:0] d0_data, d1_data;
    logic        d0_valid, d1_valid;
    logic [5:0]  d0_idx, d1_idx;
    logic        d0_fd, d1_fd;
    logic [1:0]  d0_bc, d1_bc;
    logic        d0_resync, d1_resync;

    always #5 clk = ~clk;

    uart_word_packer #(
        .WORDS_PER_FRAME (WPF),
        .MSB_FIRST       (1'b1),
        .TIMEOUT_CYCLES  (TO)
    ) u_dut_msb (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_frame_err  (rx_frame_err),
        .flush         (flush),
        .o_data_32bit  (d0_data),
        .o_valid       (d0_valid),
        .word_index    (d0_idx),
        .frame_done    (d0_fd),
        .byte_cnt      (d0_bc),
        .resync        (d0_resync)
    );

    uart_word_packer #(
        .WORDS_PER_FRAME (WPF),
        .MSB_FIRST       (1'b0),
        .TIMEOUT_CYCLES  (TO)
    ) u_dut_lsb (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_frame_err  (rx_frame_err),
        .flush         (flush),
        .o_data_32bit  (d1_data),
        .o_valid       (d1_valid),
        .word_index    (d1_idx),
        .frame_done    (d1_fd),
        .byte_cnt      (d1_bc),
        .resync        (d1_resync)
    );

    typedef struct {
        logic [31:0] data;   // MSB-first packing
        logic [5:0]  idx;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state (expected outputs for the next sample).
    int         m_bc, m_wc, m_idle;
    logic       m_valid, m_resync;
    logic [7:0] m_bytes[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the model's expectation for this cycle.
    task automatic sample();
        exp_t e;
        check("valid", d0_valid, m_valid);
        check("valid_lsb", d1_valid, m_valid);
        check("resync", d0_resync, m_resync);
        check("byte_cnt", d0_bc, m_bc[1:0]);
        if (m_valid) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_msb", d0_data, e.data);
                check("data_lsb", d1_data,
                      {e.data[7:0], e.data[15:8], e.data[23:16], e.data[31:24]});
                check("word_index", d0_idx, e.idx);
                check("frame_done", d0_fd, e.fd);
                check("word_index_lsb", d1_idx, e.idx);
            end
        end else begin
            check("frame_done_idle", d0_fd, 0);
        end
    endtask

    // One clock: sample previous results, then drive this cycle's inputs.
    task automatic cycle(input logic v, input logic [7:0] b, input logic err, input logic f);
        exp_t e;
        @(negedge clk);
        sample();
        rx_byte_valid = v;
        rx_byte       = b;
        rx_frame_err  = err;
        flush         = f;
        m_valid  = 1'b0;
        m_resync = 1'b0;
        if (f) begin
            m_resync = (m_bc != 0);
            m_bc     = 0;
            m_wc     = 0;
            m_idle   = 0;
        end else if (v && err) begin
            m_resync = (m_bc != 0);
            m_bc     = 0;
            m_idle   = 0;
        end else if (v) begin
            m_bytes[m_bc] = b;
            m_idle        = 0;
            if (m_bc == 3) begin
                e.data  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                e.idx   = 6'(m_wc);
                e.fd    = (m_wc == WPF - 1);
                sb.push_back(e);
                m_valid = 1'b1;
                m_wc    = (m_wc == WPF - 1) ? 0 : m_wc + 1;
                m_bc    = 0;
            end else begin
                m_bc = m_bc + 1;
            end
        end else begin
`ifdef UART_WORD_TIMEOUT_EN
            if (m_bc != 0) begin
                if (m_idle == TO - 1) begin
                    m_bc     = 0;
                    m_resync = 1'b1;
                    m_idle   = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
            end else begin
                m_idle = 0;
            end
`endif
        end
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, d0_data, 0);
        check({tag, "_valid"}, d0_valid, 0);
        check({tag, "_idx"}, d0_idx, 0);
        check({tag, "_fd"}, d0_fd, 0);
        check({tag, "_bc"}, d0_bc, 0);
        check({tag, "_resync"}, d0_resync, 0);
        check({tag, "_data_lsb"}, d1_data, 0);
    endtask

    task automatic clear_model();
        m_bc = 0; m_wc = 0; m_idle = 0;
        m_valid = 1'b0; m_resync = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        rx_byte = 8'h00; rx_byte_valid = 1'b0; rx_frame_err = 1'b0; flush = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Basic word: 0x12345678 MSB-first, 0x78563412 LSB-first, index 0.
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        idle(2);

        // Full frame of random bytes back-to-back, then wrap to index 0.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4 * WPF; i++) send(8'($urandom_range(0, 255)));
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        idle(1);

        // Framing error after 2 bytes: resync, index continues.
        send(8'h01); send(8'h02);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(1);

        // Idle gap after 3 bytes.
        send(8'h31); send(8'h32); send(8'h33);
        idle(TO);
`ifdef UART_WORD_TIMEOUT_EN
        send(8'h41); send(8'h42); send(8'h43); send(8'h44);
`else
        send(8'h34);
`endif
        idle(2);

        // Flush colliding with a byte strobe at bc=2.
        send(8'h51); send(8'h52);
        cycle(1'b1, 8'h53, 1'b0, 1'b1);
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        idle(1);

        // Reset asserted mid-way through word 10.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
        send(8'h71); send(8'h72); send(8'h73);
        @(negedge clk);
        sample();
        rx_byte_valid = 1'b0; rx_frame_err = 1'b0; flush = 1'b0;
        rst = 1'b1;
        clear_model();
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        check_reset_values("held_reset");
        rst = 1'b0;
        send(8'h81); send(8'h82); send(8'h83); send(8'h84);
        idle(3);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Packs the byte stream from the UART receiver into 32-bit Q-format words for the SOML decoder load FSM. It sits between the UART RX byte output and the decoder's 48-word H/Y loader, and drives `o_data_32bit`/`o_valid`. It also tracks the word position inside a 48-word frame. It recovers byte alignment after framing errors, explicit flushes or host stalls.

## Interface

Parameters:
- `WORDS_PER_FRAME`, default 48: words per frame (32 H + 16 Y).
- `MSB_FIRST`, default 1: 1 = first received byte lands in [31:24]; 0 = first byte lands in [7:0].
- `TIMEOUT_CYCLES`, default 50000: inter-byte idle limit in clk cycles (1 ms at 50 MHz). Used only with `UART_WORD_TIMEOUT_EN`.

Ports (async active-high reset; all outputs are registered):
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_byte`  in  8  received byte.
- `rx_byte_valid`  in  1  single-cycle strobe qualifying `rx_byte`.
- `rx_frame_err`  in  1  stop-bit error on the strobed byte; sampled only when `rx_byte_valid`=1.
- `flush`  in  1  synchronous abort of the partial word and of the frame position.
- `o_data_32bit`  out  32  assembled word; holds its value until the next word.
- `o_valid`  out  1  one-cycle pulse, new word present.
- `word_index`  out  6  frame position of the word on `o_data_32bit`, 0..WORDS_PER_FRAME-1.
- `frame_done`  out  1  one-cycle pulse coincident with `o_valid` of the last word in a frame.
- `byte_cnt`  out  2  bytes currently held in the partial word (0..3).
- `resync`  out  1  one-cycle pulse when a partial word is discarded (error, flush or timeout).

## Operation

- Internal state:
  - byte counter `bc` (0..3);
  - 24-bit shift register for the partial word;
  - frame word counter `wc` (0..WORDS_PER_FRAME-1).
- Byte intake: on `rx_byte_valid`=1 and `rx_frame_err`=0, the byte is appended in the order set by `MSB_FIRST`.
  - If `bc`<3: `bc` increments.
  - If `bc`=3: the word is completed, `bc` returns to 0, `o_valid` pulses, `word_index` takes `wc`, and `wc` advances.
- Frame wrap: when the completed word has `wc`=WORDS_PER_FRAME-1, `frame_done` pulses and `wc` wraps to 0.
- Framing error: `rx_byte_valid`=1 with `rx_frame_err`=1 drops the byte and clears `bc` to 0. If `bc` was nonzero, `resync` pulses. `wc` is unchanged.
- Flush: `flush`=1 clears `bc` and `wc`. `resync` pulses if `bc` was nonzero. Flush has priority over a simultaneous byte strobe, so that byte is dropped.
- Arithmetic: `wc` and `bc` are unsigned counters, and no sign handling is applied. Words pass through bit-exact for downstream Q22 interpretation.

## Timing

- Reset values: `o_data_32bit`=0, `o_valid`=0, `word_index`=0, `frame_done`=0, `byte_cnt`=0, `resync`=0, and the internal `wc`=0.
- Reset asserted mid-word discards all partial state immediately. No `resync` pulse is produced.
- Latency: `o_valid` rises exactly 1 cycle after the `rx_byte_valid` that carries the 4th byte.
- Throughput: back-to-back strobes on consecutive cycles are accepted, up to one word per 4 cycles.
- No backpressure: the consumer must take each word on the `o_valid` cycle.
- `byte_cnt` reflects the update 1 cycle after each strobe.

## Configuration

- `UART_WORD_TIMEOUT_EN` defined:
  - an idle counter runs while `bc`≠0 and resets on every accepted or dropped byte;
  - on reaching TIMEOUT_CYCLES-1 with no strobe, the next cycle clears `bc` and pulses `resync`; `wc` is kept;
  - a strobe in the expiry cycle counts as arrival, so there is no timeout.
- `UART_WORD_TIMEOUT_EN` undefined: no timer logic is built, partial words are held indefinitely, and `resync` comes only from errors or flush.

## Structure

- Shared package `soml_uart_pkg`: `WORDS_PER_FRAME` (48), `BYTES_PER_WORD` (4), `UART_TIMEOUT_CYCLES` (50000), and the width constant for `word_index` (6).
- One sub-module, `uart_idle_timer` (load/clear/expire). It is instantiated only under `UART_WORD_TIMEOUT_EN`.

## Test plan

- Bytes 0x12,0x34,0x56,0x78 on consecutive cycles with `MSB_FIRST`=1 → `o_data_32bit`=0x12345678 and `o_valid` pulse 1 cycle after the 4th byte, `word_index`=0. With `MSB_FIRST`=0 → 0x78563412.
- 192 random bytes → 48 `o_valid` pulses with `word_index` 0..47. `frame_done` pulses only with word 47. The next word reports `word_index`=0.
- 2 bytes, then a strobe with `rx_frame_err`=1, then 0xAA,0xBB,0xCC,0xDD → one `resync` pulse, then 0xAABBCCDD, with `word_index` continuing unchanged.
- Timeout with the macro defined and `TIMEOUT_CYCLES`=100: 3 bytes then 100 idle cycles → `resync`, `byte_cnt`=0. The following 4 bytes form a clean word. With the macro undefined → no `resync` is produced, and the 4th byte completes the stale word.
- Flush on the same cycle as a byte strobe at `bc`=2 → byte dropped, `resync` pulses, `byte_cnt`=0, next word has `word_index`=0.
- `rst` asserted for 1 cycle after 3 bytes of word 10 → all outputs return to reset values. The next 4 bytes yield `word_index`=0 and no spurious `o_valid`.
